ram2_master: RTL
================

RAM2_MASTER -- requirements
Module: ram2_master

Interface
REQ-001 SHALL have parameter RD_WAIT, default 1, meaning the number of RD_CAPTURE cycles spent before data is sampled (range 1..4).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req_i  input  1  instruction-fetch request.
- pc_i  input  32  instruction fetch address.
- inst_o  output  32  fetched instruction.
- if_stall_o  output  1  fetch not complete.
- mem_re_i  input  1  data read request.
- mem_we_i  input  1  data write request.
- mem_addr_i  input  32  data address.
- mem_data_i  input  32  write data.
- mem_data_o  output  32  read data.
- mem_stall_o  output  1  data access not complete.
- ram_addr_o  output  32  RAM2 address.
- ram_data_o  output  32  RAM2 write data.
- ram_data_i  input  32  RAM2 read data.
- ram_ce_o  output  1  RAM2 chip enable, active-high.
- ram_re_o  output  1  RAM2 read enable, active-high.
- ram_we_o  output  1  RAM2 write strobe, active-high.

Function
REQ-003 SHALL implement the FSM states IDLE, RD_SETUP, RD_CAPTURE, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-004 SHALL, in IDLE, choose the request to serve: data first (mem_we_i or mem_re_i), else fetch (if_req_i), else stay in IDLE.
REQ-005 SHALL treat mem_we_i as taking priority over mem_re_i when both are high; the access is a write only.
REQ-006 SHALL, on accepting a request, latch the address, the write data and the requester identity (IF or MEM); later changes to the inputs SHALL NOT affect the access in progress.
REQ-007 SHALL follow the read path IDLE -> RD_SETUP -> RD_CAPTURE (RD_WAIT cycles) -> DONE.
- ram_ce_o and ram_re_o are high in RD_SETUP and RD_CAPTURE.
- ram_data_i is sampled into the result register at the end of the last RD_CAPTURE cycle.
REQ-008 SHALL follow the write path IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> DONE.
- ram_ce_o is high in all three write states.
- ram_we_o is high only in WR_PULSE.
- ram_addr_o and ram_data_o are stable across all three write states.
REQ-009 SHALL go from DONE to IDLE unconditionally; DONE lasts exactly one cycle.
REQ-010 SHALL drive mem_stall_o combinationally: high when mem_re_i or mem_we_i is high and the FSM is not in DONE serving MEM.
REQ-011 SHALL drive if_stall_o combinationally: high when if_req_i is high and the FSM is not in DONE serving IF, or whenever mem_stall_o is high.
REQ-012 SHALL make inst_o or mem_data_o (whichever matches the served requester) equal the captured word in the DONE cycle and hold that value until the next capture for the same requester; a write SHALL NOT change mem_data_o.
REQ-013 SHALL use these latencies with RD_WAIT=1, counting the acceptance cycle T as cycle 0:
- read: DONE at T+3 (stall high in T..T+2, low in T+3).
- write: DONE at T+4.
REQ-014 SHALL drive ram_ce_o, ram_re_o and ram_we_o low in IDLE and DONE, and SHALL drive ram_addr_o and ram_data_o from the latched registers.
REQ-015 SHALL accept a request still asserted in IDLE after DONE as a new access (the CPU advances in the DONE cycle).
REQ-016 SHALL use a RD_CAPTURE wait counter that resets to 0 on entry to the state and never wraps.

Reset
REQ-017 SHALL, while rst is high, asynchronously force:
- state to IDLE.
- ram_ce_o, ram_re_o and ram_we_o to 0.
- ram_addr_o, ram_data_o, inst_o and mem_data_o to 0x00000000.
- the latched requester to IF.
REQ-018 SHALL abandon any access in progress on reset, including a reset in WR_PULSE, with ram_we_o dropping without waiting for a clock edge.
REQ-019 SHALL hold both stall outputs per REQ-010/011 during reset, so a pending request reads as stalled.

Verification
REQ-020 Fetch: if_req_i=1, pc_i=0x10, ram_data_i=0x3C010001 -> if_stall_o high for 3 cycles; inst_o=0x3C010001 in the DONE cycle at T+3.
REQ-021 Write: mem_we_i=1, mem_addr_i=0x20, mem_data_i=0xDEADBEEF -> ram_we_o high for exactly one cycle (T+2), with addr 0x20 and data 0xDEADBEEF held over T+1..T+3; mem_stall_o low at T+4.
REQ-022 Conflict: if_req_i=1 and mem_re_i=1 in the same cycle -> data read served first, with if_stall_o high throughout it; fetch then accepted in the following IDLE; total 8 cycles until if_stall_o is low.
REQ-023 Both enables: mem_re_i=1 and mem_we_i=1 -> write sequence only; mem_data_o unchanged.
REQ-024 Reset in WR_PULSE -> ram_we_o=0 in the same cycle; state IDLE after reset is released; no DONE pulse.
REQ-025 RD_WAIT=3 -> read DONE at T+5; data sampled at the end of the third RD_CAPTURE cycle.

Source files
------------

// File: rtl/ram2_master.sv
// ram2_master: single-port RAM2 sequencer shared by the fetch and data ports.
// Data accesses win over fetch; every access is a fixed multi-cycle RAM handshake.
module ram2_master #(
    parameter int RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic        if_stall_o,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stall_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        ram_ce_o,
    output logic        ram_re_o,
    output logic        ram_we_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_CAPTURE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [2:0] LAST_WAIT = 3'(RD_WAIT - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_req_mem;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_inst;
    logic [31:0] r_mdata;
    logic        r_ce;
    logic        r_re;
    logic        r_we;

    logic        w_mem_req;
    logic        w_done_mem;
    logic        w_done_if;
    logic        w_mem_stall;

    assign w_mem_req   = mem_re_i | mem_we_i;
    assign w_done_mem  = (r_state == DONE) && r_req_mem;
    assign w_done_if   = (r_state == DONE) && !r_req_mem;
    assign w_mem_stall = w_mem_req && !w_done_mem;

    assign mem_stall_o = w_mem_stall;
    assign if_stall_o  = (if_req_i && !w_done_if) || w_mem_stall;

    assign inst_o      = r_inst;
    assign mem_data_o  = r_mdata;
    assign ram_addr_o  = r_addr;
    assign ram_data_o  = r_wdata;
    assign ram_ce_o    = r_ce;
    assign ram_re_o    = r_re;
    assign ram_we_o    = r_we;

    // Strobes are registered from the transition so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_req_mem <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_inst    <= 32'h0;
            r_mdata   <= 32'h0;
            r_ce      <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_mem_req) begin
                        r_req_mem <= 1'b1;
                        r_addr    <= mem_addr_i;
                        r_wdata   <= mem_data_i;
                        r_ce      <= 1'b1;
                        if (mem_we_i) begin
                            r_state <= WR_SETUP;
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= RD_SETUP;
                        end
                    end else if (if_req_i) begin
                        r_req_mem <= 1'b0;
                        r_addr    <= pc_i;
                        r_ce      <= 1'b1;
                        r_re      <= 1'b1;
                        r_state   <= RD_SETUP;
                    end
                end
                RD_SETUP: begin
                    r_cnt   <= 3'd0;
                    r_state <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    if (r_cnt == LAST_WAIT) begin
                        if (r_req_mem) begin
                            r_mdata <= ram_data_i;
                        end else begin
                            r_inst <= ram_data_i;
                        end
                        r_ce    <= 1'b0;
                        r_re    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                WR_SETUP: begin
                    r_we    <= 1'b1;
                    r_state <= WR_PULSE;
                end
                WR_PULSE: begin
                    r_we    <= 1'b0;
                    r_state <= WR_HOLD;
                end
                WR_HOLD: begin
                    r_ce    <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_ce    <= 1'b0;
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
